keypad_scanner: RTL

- Scans a 4x4 matrix keypad (Pmod KYPD style) by driving one column low at a time and reading the four row lines.
- Debounces across full scans, produces a one-cycle strobe with the hex key code, and builds a two-digit decimal entry VALUE (0..99).
- VALUE feeds the two-digit seven-segment display's 7-bit switch input, replacing SW as the number source.

---
 rtl/keypad_scanner.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with scan-level debounce and a two-digit decimal entry register.
// Optional auto-repeat of held keys is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SLOT_CYCLES    = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 250
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KEY,
  output logic       KEY_VALID,
  output logic       KEY_STROBE,
  output logic [6:0] VALUE
);

  localparam int unsigned SlotW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned StabW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SLOT_CYCLES - 1);
  localparam logic [StabW-1:0] StabMax  = StabW'(DEBOUNCE_SCANS);

  logic [3:0]       row_s1_q, row_s2_q;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       hits_q, hits_d;      // pressed positions seen this scan, saturating at 2
  logic [3:0]       code_acc_q, code_acc_d;
  logic [4:0]       prev_q, prev_d;      // {valid, code}; 0 means none
  logic [StabW-1:0] stable_q, stable_d;
  logic [3:0]       key_q, key_d;
  logic             valid_q, valid_d;
  logic             strobe_q, strobe_d;
  logic [6:0]       value_q, value_d;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RepW-1:0] RepMax = RepW'(REPEAT_SCANS);
  logic [RepW-1:0] rep_q, rep_d;
`endif

  logic [3:0] row_low;
  logic [2:0] col_cnt;
  logic [1:0] row_idx, col_idx;
  logic [2:0] sum;
  logic [1:0] hits_sat;
  logic [3:0] code_now;
  logic [4:0] result;
  logic       same, commit, fire;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [6:0] next_value(input logic [6:0] v, input logic [3:0] k);
    logic [6:0] n;
    if (k <= 4'd9)       n = ((v % 7'd10) * 7'd10) + {3'b000, k};
    else if (k == 4'hC)  n = 7'd0;
    else                 n = v;
    return n;
  endfunction

  always_comb begin
    row_low = ~row_s2_q;
    col_cnt = 3'(row_low[0]) + 3'(row_low[1]) + 3'(row_low[2]) + 3'(row_low[3]);
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_low[i]) row_idx = 2'(i);
    end
    unique case (col_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    sum      = 3'(hits_q) + col_cnt;
    hits_sat = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    code_now = (col_cnt == 3'd1) ? key_code(row_idx, col_idx) : code_acc_q;
  end

  always_comb begin
    slot_d     = slot_q + SlotW'(1);
    col_d      = col_q;
    hits_d     = hits_q;
    code_acc_d = code_acc_q;
    prev_d     = prev_q;
    stable_d   = stable_q;
    key_d      = key_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;
    value_d    = value_q;
    result     = 5'd0;
    same       = 1'b0;
    commit     = 1'b0;
    fire       = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d      = rep_q;
`endif
    if (slot_q == SlotLast) begin
      slot_d = '0;
      col_d  = {col_q[2:0], col_q[3]};
      if (col_idx != 2'd3) begin
        hits_d     = hits_sat;
        code_acc_d = code_now;
      end else begin
        hits_d     = 2'd0;
        code_acc_d = 4'd0;
        result     = (hits_sat == 2'd1) ? {1'b1, code_now} : 5'd0;
        same       = (result == prev_q);
        prev_d     = result;
        if (!same)                  stable_d = StabW'(1);
        else if (stable_q != StabMax) stable_d = stable_q + StabW'(1);
        // Commit only on the scan that first reaches the threshold.
        commit = (stable_d == StabMax) && !(same && (stable_q == StabMax));
        if (commit) begin
          if (result[4]) begin
            key_d   = result[3:0];
            valid_d = 1'b1;
            fire    = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (commit) begin
          rep_d = '0;
        end else if (valid_q && (result == {1'b1, key_q})) begin
          rep_d = rep_q + RepW'(1);
          if (rep_d == RepMax) begin
            rep_d = '0;
            fire  = 1'b1;
          end
        end
`endif
        if (fire) begin
          strobe_d = 1'b1;
          value_d  = next_value(value_q, key_d);
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      slot_q     <= '0;
      col_q      <= 4'b1110;
      hits_q     <= 2'd0;
      code_acc_q <= 4'd0;
      prev_q     <= 5'd0;
      stable_q   <= '0;
      key_q      <= 4'd0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      value_q    <= 7'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      row_s1_q   <= ROW;
      row_s2_q   <= row_s1_q;
      slot_q     <= slot_d;
      col_q      <= col_d;
      hits_q     <= hits_d;
      code_acc_q <= code_acc_d;
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      value_q    <= value_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  assign COL        = col_q;
  assign KEY        = key_q;
  assign KEY_VALID  = valid_q;
  assign KEY_STROBE = strobe_q;
  assign VALUE      = value_q;

endmodule
